// File: rtl/ifm_bank_scheduler_if.sv
// Producer/consumer handshake bundle for the IFM bank ring scheduler.
// master = scheduler side, slave = producer/consumer layer side.
interface ifm_bank_scheduler_if #(
   parameter int unsigned BANK_SEL_WIDTH = 1
);
   logic                      prod_done;
   logic                      prod_grant;
   logic [BANK_SEL_WIDTH-1:0] prod_wr_bank;
   logic                      cons_ready;
   logic                      cons_release;
   logic                      cons_start;
   logic [BANK_SEL_WIDTH-1:0] cons_rd_bank;

   modport master (
      input  prod_done,
      input  cons_ready,
      input  cons_release,
      output prod_grant,
      output prod_wr_bank,
      output cons_start,
      output cons_rd_bank
   );

   modport slave (
      output prod_done,
      output cons_ready,
      output cons_release,
      input  prod_grant,
      input  prod_wr_bank,
      input  cons_start,
      input  cons_rd_bank
   );
endinterface

// File: rtl/ifm_bank_scheduler.sv
// IFM bank ring scheduler: grants free banks to the producer layer, hands full banks to the
// consumer layer. Optional perf counters enabled by defining IFM_BANK_PERF_EN.
module ifm_bank_scheduler #(
   parameter int unsigned NUMBER_OF_BANKS = 2,
   parameter int unsigned FRAME_CNT_WIDTH = 16,
   localparam int unsigned BANK_SEL_WIDTH = $clog2(NUMBER_OF_BANKS)
) (
   input  logic                       clk,
   input  logic                       reset,
   ifm_bank_scheduler_if.master       bus,
   output logic [NUMBER_OF_BANKS-1:0] bank_full,
   output logic [FRAME_CNT_WIDTH-1:0] frame_count,
   output logic                       err_sticky
`ifdef IFM_BANK_PERF_EN
   ,
   output logic [15:0]                prod_stall_cycles,
   output logic [15:0]                cons_starve_cycles
`endif
);

   // FILLING is implicit: the bank at wp while the producer writes it stays FREE.
   typedef enum logic [1:0] {BankFree, BankFull, BankDraining} bank_e;
   typedef enum logic [0:0] {CIdle, CBusy} cons_e;

   bank_e                      bank_q [NUMBER_OF_BANKS];
   bank_e                      bank_d [NUMBER_OF_BANKS];
   cons_e                      state_q, state_d;
   logic [BANK_SEL_WIDTH-1:0]  wp_q, wp_d, rp_q, rp_d;
   logic                       cons_start_q, cons_start_d;
   logic [FRAME_CNT_WIDTH-1:0] frame_q, frame_d;
   logic                       err_q, err_d;
   logic                       grant;

   function automatic logic [BANK_SEL_WIDTH-1:0] ptr_inc(input logic [BANK_SEL_WIDTH-1:0] p);
      return (p == BANK_SEL_WIDTH'(NUMBER_OF_BANKS - 1)) ? '0 : p + 1'b1;
   endfunction

   assign grant = (bank_q[wp_q] == BankFree);

   always_comb begin
      bank_d       = bank_q;
      state_d      = state_q;
      wp_d         = wp_q;
      rp_d         = rp_q;
      cons_start_d = 1'b0;
      frame_d      = frame_q;
      err_d        = err_q;

      if (bus.prod_done) begin
         if (grant) begin
            bank_d[wp_q] = BankFull;
            wp_d         = ptr_inc(wp_q);
         end else begin
            err_d = 1'b1;
         end
      end

      // The consumer only ever touches bank[rp], which cannot be the FREE bank at wp.
      unique case (state_q)
         CIdle: begin
            if (bus.cons_release) err_d = 1'b1;
            if (bank_q[rp_q] == BankFull && bus.cons_ready) begin
               cons_start_d = 1'b1;
               bank_d[rp_q] = BankDraining;
               state_d      = CBusy;
            end
         end
         CBusy: begin
            if (bus.cons_release) begin
               bank_d[rp_q] = BankFree;
               rp_d         = ptr_inc(rp_q);
               frame_d      = frame_q + 1'b1;
               state_d      = CIdle;
            end
         end
         default: state_d = CIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUMBER_OF_BANKS; i++) bank_q[i] <= BankFree;
         state_q      <= CIdle;
         wp_q         <= '0;
         rp_q         <= '0;
         cons_start_q <= 1'b0;
         frame_q      <= '0;
         err_q        <= 1'b0;
      end else begin
         bank_q       <= bank_d;
         state_q      <= state_d;
         wp_q         <= wp_d;
         rp_q         <= rp_d;
         cons_start_q <= cons_start_d;
         frame_q      <= frame_d;
         err_q        <= err_d;
      end
   end

   always_comb begin
      bank_full = '0;
      for (int i = 0; i < NUMBER_OF_BANKS; i++) begin
         bank_full[i] = (bank_q[i] != BankFree);
      end
   end

   assign bus.prod_grant   = grant;
   assign bus.prod_wr_bank = wp_q;
   assign bus.cons_start   = cons_start_q;
   assign bus.cons_rd_bank = rp_q;
   assign frame_count      = frame_q;
   assign err_sticky       = err_q;

`ifdef IFM_BANK_PERF_EN
   logic [15:0] stall_q, stall_d, starve_q, starve_d;

   always_comb begin
      stall_d  = stall_q;
      starve_d = starve_q;
      if (!grant && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
      if (state_q == CIdle && bus.cons_ready && bank_q[rp_q] != BankFull &&
          starve_q != 16'hFFFF) begin
         starve_d = starve_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_q  <= '0;
         starve_q <= '0;
      end else begin
         stall_q  <= stall_d;
         starve_q <= starve_d;
      end
   end

   assign prod_stall_cycles  = stall_q;
   assign cons_starve_cycles = starve_q;
`endif

endmodule
